jtag_dr_bridge: RTL and testbench

JTAG_DR_BRIDGE -- requirements
Module: jtag_dr_bridge

---
 rtl/jtag_dr_bridge.sv | 158 +++++++++++++++
 tb/tb_jtag_dr_bridge.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/jtag_dr_bridge.sv
// jtag_dr_bridge: user-DR bridge between a JTAG TAP and a core.
// Inbound: tdi bits (after LEAD_SKIP_BITS bypass bits) are assembled LSB first
// into SYMBOL_WIDTH-bit symbols and queued in a small FIFO for the core.
// Outbound: the latest core result is captured and shifted out on tdo.
// Optional macro JTAG_DR_BRIDGE_STATS_EN enables the accepted-symbol counter;
// without it symbol_count is tied to zero.
module jtag_dr_bridge #(
    parameter int SYMBOL_WIDTH   = 8,
    parameter int RESULT_WIDTH   = 16,
    parameter int LEAD_SKIP_BITS = 1,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                    tck,
    input  logic                    test_logic_reset,
    input  logic                    ir_is_user,
    input  logic                    capture_dr,
    input  logic                    shift_dr,
    input  logic                    update_dr,
    input  logic                    tdi,
    output logic                    tdo,
    output logic                    out_valid,
    output logic [SYMBOL_WIDTH-1:0] out_data,
    input  logic                    out_ready,
    output logic                    scan_done,
    input  logic                    res_valid,
    input  logic [RESULT_WIDTH-1:0] res_data,
    output logic                    overflow,
    output logic [31:0]             symbol_count
);

    localparam int SKIP_W = (LEAD_SKIP_BITS > 0) ? $clog2(LEAD_SKIP_BITS + 1) : 1;
    localparam int BIT_W  = (SYMBOL_WIDTH > 1) ? $clog2(SYMBOL_WIDTH) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    localparam logic [SKIP_W-1:0] SKIP_LOAD = SKIP_W'(LEAD_SKIP_BITS);
    localparam logic [SKIP_W-1:0] SKIP_ONE  = SKIP_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(SYMBOL_WIDTH - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]    CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]    CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

    logic [SKIP_W-1:0]       skip_q;
    logic [BIT_W-1:0]        bit_q;
    logic [SYMBOL_WIDTH-1:0] asm_q;
    logic [SYMBOL_WIDTH-1:0] sym_next;
    logic [SYMBOL_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W:0]          count_q;
    logic [RESULT_WIDTH-1:0] hold_q;
    logic                    hold_vld;
    logic [RESULT_WIDTH-1:0] rb_q;

    logic cap, upd, act, data_bit, sym_done, pop, full, push, drop;

    // Capture wins over shift so a malformed qualifier overlap cannot half-load.
    assign cap      = ir_is_user & capture_dr;
    assign upd      = ir_is_user & update_dr;
    assign act      = ir_is_user & shift_dr & ~capture_dr;
    assign data_bit = act & (skip_q == '0);
    assign sym_done = data_bit & (bit_q == BIT_LAST);
    assign pop      = out_valid & out_ready;
    assign full     = (count_q == CNT_FULL);
    assign push     = sym_done & (~full | pop);
    assign drop     = sym_done & full & ~pop;

    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign tdo       = rb_q[0];

    // Assembly register with the current tdi bit merged in at its position.
    always_comb begin
        sym_next        = asm_q;
        sym_next[bit_q] = tdi;
    end

    // Skip down-counter, bit position and partial-symbol assembly.
    always_ff @(posedge tck or posedge test_logic_reset) begin
        if (test_logic_reset) begin
            skip_q <= '0;
            bit_q  <= '0;
            asm_q  <= '0;
        end else if (cap) begin
            skip_q <= SKIP_LOAD;
            bit_q  <= '0;
        end else if (upd) begin
            bit_q  <= '0;
        end else if (act) begin
            if (skip_q != '0) begin
                skip_q <= skip_q - SKIP_ONE;
            end else begin
                asm_q <= sym_next;
                bit_q <= sym_done ? '0 : bit_q + BIT_ONE;
            end
        end
    end

    // FIFO storage; emptiness is tracked by count_q so no reset is needed here.
    always_ff @(posedge tck) begin
        if (push) begin
            mem[wr_ptr] <= sym_next;
        end
    end

    // FIFO pointers, occupancy and sticky drop flag.
    always_ff @(posedge tck or posedge test_logic_reset) begin
        if (test_logic_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push & ~pop)      count_q <= count_q + CNT_ONE;
            else if (pop & ~push) count_q <= count_q - CNT_ONE;
            if (drop) overflow <= 1'b1;
        end
    end

    // One-cycle end-of-scan pulse following update_dr.
    always_ff @(posedge tck or posedge test_logic_reset) begin
        if (test_logic_reset) scan_done <= 1'b0;
        else                  scan_done <= upd;
    end

    // Result hold register and readback shifter (zeros once exhausted).
    always_ff @(posedge tck or posedge test_logic_reset) begin
        if (test_logic_reset) begin
            hold_q   <= '0;
            hold_vld <= 1'b0;
            rb_q     <= '0;
        end else begin
            if (res_valid) begin
                hold_q   <= res_data;
                hold_vld <= 1'b1;
            end
            if (cap)      rb_q <= hold_vld ? hold_q : '0;
            else if (act) rb_q <= rb_q >> 1;
        end
    end

`ifdef JTAG_DR_BRIDGE_STATS_EN
    logic [31:0] stat_q;

    // Accepted-symbol counter; drops are not counted, wraps naturally.
    always_ff @(posedge tck or posedge test_logic_reset) begin
        if (test_logic_reset) stat_q <= '0;
        else if (push)        stat_q <= stat_q + 32'd1;
    end

    assign symbol_count = stat_q;
`else
    assign symbol_count = '0;
`endif

endmodule

// File: tb/tb_jtag_dr_bridge.sv
// Directed bench for jtag_dr_bridge: default instance plus a 4-bit/no-skip one.
module tb_jtag_dr_bridge;

`ifdef JTAG_DR_BRIDGE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic tck = 1'b0;
    logic rst, ir_main, ir_alt, capture_dr, shift_dr, update_dr, tdi;
    logic tdo, out_valid, out_ready, scan_done, res_valid, overflow;
    logic [7:0]  out_data;
    logic [15:0] res_data;
    logic [31:0] symbol_count;
    logic tdo4, out_valid4, out_ready4, scan_done4, res_valid4, overflow4;
    logic [3:0]  out_data4;
    logic [15:0] res_data4;
    logic [31:0] symbol_count4;
    logic [63:0] tb_bits;

    int checks = 0;
    int failures = 0;

    always #5 tck = ~tck;

    jtag_dr_bridge dut (
        .tck(tck), .test_logic_reset(rst), .ir_is_user(ir_main),
        .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
        .tdi(tdi), .tdo(tdo), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .scan_done(scan_done), .res_valid(res_valid),
        .res_data(res_data), .overflow(overflow), .symbol_count(symbol_count)
    );

    jtag_dr_bridge #(.SYMBOL_WIDTH(4), .LEAD_SKIP_BITS(0)) dut4 (
        .tck(tck), .test_logic_reset(rst), .ir_is_user(ir_alt),
        .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
        .tdi(tdi), .tdo(tdo4), .out_valid(out_valid4), .out_data(out_data4),
        .out_ready(out_ready4), .scan_done(scan_done4), .res_valid(res_valid4),
        .res_data(res_data4), .overflow(overflow4), .symbol_count(symbol_count4)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Full DR scan entered and left on a negedge; records tdo before each shift edge.
    task automatic do_scan(input int nbits, input logic [63:0] bits, input bit pop_last,
                           input bit alt, output logic [63:0] tdo_bits);
        tdo_bits = '0;
        capture_dr = 1'b1;
        @(negedge tck);
        capture_dr = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            shift_dr  = 1'b1;
            tdi       = bits[i];
            out_ready = pop_last && (i == nbits - 1);
            tdo_bits[i] = alt ? tdo4 : tdo;
            @(negedge tck);
        end
        shift_dr  = 1'b0;
        out_ready = 1'b0;
        update_dr = 1'b1;
        @(negedge tck);
        update_dr = 1'b0;
        check_eq("scan_done_pulse", alt ? scan_done4 : scan_done, 1);
        check_eq("scan_done_other", alt ? scan_done : scan_done4, 0);
        @(negedge tck);
        check_eq("scan_done_clear", alt ? scan_done4 : scan_done, 0);
    endtask

    task automatic pop_one(input bit alt, input logic [7:0] exp);
        check_eq("pop_valid", alt ? out_valid4 : out_valid, 1);
        check_eq("pop_data", alt ? {4'h0, out_data4} : out_data, exp);
        if (alt) out_ready4 = 1'b1;
        else     out_ready  = 1'b1;
        @(negedge tck);
        out_ready  = 1'b0;
        out_ready4 = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge tck);
        rst = 1'b0;
        @(negedge tck);
    endtask

    initial begin
        rst = 1'b1; ir_main = 1'b1; ir_alt = 1'b0;
        capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0; tdi = 1'b0;
        out_ready = 1'b0; out_ready4 = 1'b0;
        res_valid = 1'b0; res_data = '0; res_valid4 = 1'b0; res_data4 = '0;

        // Reset state
        @(negedge tck);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_scan_done", scan_done, 0);
        check_eq("rst_tdo", tdo, 0);
        check_eq("rst_count", symbol_count, 0);
        rst = 1'b0;
        @(negedge tck);

        // Skip bit then 0x41, 0x0A; no result loaded so readback is zero
        do_scan(17, {8'h0A, 8'h41, 1'b0}, 0, 0, tb_bits);
        check_eq("noresult_tdo", tb_bits[15:0], 16'h0000);
        pop_one(0, 8'h41);
        pop_one(0, 8'h0A);
        check_eq("two_empty", out_valid, 0);
        check_eq("two_overflow", overflow, 0);

        // Readback of 0x1234, bits past RESULT_WIDTH read zero; inbound in same scan
        res_data = 16'h1234; res_valid = 1'b1;
        @(negedge tck);
        res_valid = 1'b0;
        do_scan(20, {3'b101, 8'hC3, 8'h5A, 1'b1}, 0, 0, tb_bits);
        check_eq("readback_tdo", tb_bits[19:0], 20'h01234);
        pop_one(0, 8'h5A);
        pop_one(0, 8'hC3);
        check_eq("rb_empty", out_valid, 0);

        // Five bytes into a four-deep FIFO with no reader
        do_scan(41, {8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 1'b0}, 0, 0, tb_bits);
        check_eq("ovf_flag", overflow, 1);
        check_eq("ovf_count", symbol_count, STATS ? 8 : 0);
        pop_one(0, 8'h11);
        pop_one(0, 8'h22);
        pop_one(0, 8'h33);
        pop_one(0, 8'h44);
        check_eq("ovf_fifth_absent", out_valid, 0);

        // Push and pop on the same edge with FIFO full
        pulse_reset();
        check_eq("rst2_overflow", overflow, 0);
        do_scan(33, {8'h44, 8'h33, 8'h22, 8'h11, 1'b0}, 0, 0, tb_bits);
        do_scan(9, {8'h77, 1'b0}, 1, 0, tb_bits);
        check_eq("full_pushpop_ovf", overflow, 0);
        pop_one(0, 8'h22);
        pop_one(0, 8'h33);
        pop_one(0, 8'h44);
        pop_one(0, 8'h77);
        check_eq("full_pushpop_empty", out_valid, 0);

        // 12-bit scan: one symbol, remainder dropped, next scan aligned
        do_scan(12, {3'b111, 8'h96, 1'b0}, 0, 0, tb_bits);
        pop_one(0, 8'h96);
        check_eq("partial_empty", out_valid, 0);
        do_scan(9, {8'h3C, 1'b0}, 0, 0, tb_bits);
        pop_one(0, 8'h3C);
        check_eq("align_count", symbol_count, STATS ? 7 : 0);

        // Reset mid-symbol with a queued byte and a loaded readback
        res_data = 16'h1235; res_valid = 1'b1;
        @(negedge tck);
        res_valid = 1'b0;
        do_scan(9, {8'h81, 1'b0}, 0, 0, tb_bits);
        capture_dr = 1'b1;
        @(negedge tck);
        capture_dr = 1'b0;
        shift_dr = 1'b1; tdi = 1'b1;
        repeat (4) @(negedge tck);
        check_eq("mid_pre_valid", out_valid, 1);
        check_eq("mid_pre_tdo", tdo, 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_data", out_data, 0);
        check_eq("mid_rst_tdo", tdo, 0);
        check_eq("mid_rst_count", symbol_count, 0);
        shift_dr = 1'b0; tdi = 1'b0;
        @(negedge tck);
        rst = 1'b0;
        @(negedge tck);
        do_scan(9, {8'hE7, 1'b0}, 0, 0, tb_bits);
        check_eq("post_rst_tdo", tb_bits[8:0], 9'h000);
        pop_one(0, 8'hE7);
        check_eq("post_rst_empty", out_valid, 0);
        check_eq("post_rst_count", symbol_count, STATS ? 1 : 0);

        // Narrow instance: 0xA5 with no skip; main instance must ignore the scan
        ir_main = 1'b0; ir_alt = 1'b1;
        do_scan(8, 64'hA5, 0, 1, tb_bits);
        check_eq("ignored_valid", out_valid, 0);
        check_eq("ignored_count", symbol_count, STATS ? 1 : 0);
        check_eq("w4_count", symbol_count4, STATS ? 2 : 0);
        pop_one(1, 8'h05);
        pop_one(1, 8'h0A);
        check_eq("w4_empty", out_valid4, 0);
        check_eq("w4_overflow", overflow4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
